// File: rtl/door_lock_ctrl.sv
// rtl/door_lock_ctrl.sv - keypad code lock: entry, timed open, error blink, fail count
// Define LOCKOUT_EN to add a lockout state after MAX_FAIL consecutive failed codes.
module door_lock_ctrl #(
    parameter int NUM_KEYS = 4,
    parameter int CODE_LEN = 4,
    parameter int KW = $clog2(NUM_KEYS),
    parameter logic [CODE_LEN*KW-1:0] RESET_CODE = {2'd3, 2'd1, 2'd2, 2'd0},
    parameter int TIMEOUT = 10,
    parameter int OPEN_TIME = 3,
    parameter int BLINK_HALF = 1,
    parameter int BLINKS = 3,
    parameter int MAX_FAIL = 3,
    parameter int LOCKOUT_TIME = 20
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_KEYS-1:0]    btn,
    input  logic                   code_we,
    input  logic [CODE_LEN*KW-1:0] code_in,
    output logic                   door_open,
    output logic                   green_led,
    output logic                   red_led,
    output logic                   locked_out,
    output logic [3:0]             fail_cnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ENTRY,
        S_OPEN,
        S_ERROR
`ifdef LOCKOUT_EN
        , S_LOCKOUT
`endif
    } state_t;

    localparam logic [3:0]  LAST_DIGIT = 4'(CODE_LEN - 1);
    localparam logic [15:0] TO_LAST    = 16'(TIMEOUT - 1);
    localparam logic [15:0] OPEN_LAST  = 16'(OPEN_TIME - 1);
    localparam logic [15:0] ERR_LAST   = 16'(2 * BLINKS * BLINK_HALF - 1);
    localparam logic [15:0] BLINK_LAST = 16'(2 * BLINK_HALF - 1);
    localparam logic [15:0] BH         = 16'(BLINK_HALF);
`ifdef LOCKOUT_EN
    localparam logic [15:0] LOCK_LAST  = 16'(LOCKOUT_TIME - 1);
    localparam logic [3:0]  FAIL_LIMIT = 4'(MAX_FAIL);
`endif

    state_t                 state;
    logic [CODE_LEN*KW-1:0] code_reg;
    logic [NUM_KEYS-1:0]    btn_prev;
    logic [3:0]             digit_cnt;
    logic                   mismatch;
    logic [15:0]            timer;
    logic [15:0]            blink;

    logic [NUM_KEYS-1:0]    rise;
    logic [NUM_KEYS-1:0]    exp_hot;
    logic [KW-1:0]          cur_digit;
    logic                   press;
    logic                   mm_total;

    // A multi-key rise never equals the one-hot expectation, so it counts as a wrong digit.
    always_comb begin
        rise      = btn & ~btn_prev;
        press     = |rise;
        cur_digit = code_reg[digit_cnt*KW +: KW];
        exp_hot   = NUM_KEYS'(1) << cur_digit;
        mm_total  = mismatch | (rise != exp_hot);
    end

`ifndef LOCKOUT_EN
    assign locked_out = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            code_reg  <= RESET_CODE;
            btn_prev  <= '0;
            digit_cnt <= '0;
            mismatch  <= 1'b0;
            timer     <= '0;
            blink     <= '0;
            fail_cnt  <= '0;
            door_open <= 1'b0;
            green_led <= 1'b0;
            red_led   <= 1'b0;
`ifdef LOCKOUT_EN
            locked_out <= 1'b0;
`endif
        end else begin
            btn_prev <= btn;
            case (state)
                S_IDLE, S_ENTRY: begin
                    if (press) begin
                        timer <= '0;
                        if (digit_cnt == LAST_DIGIT) begin
                            digit_cnt <= '0;
                            mismatch  <= 1'b0;
                            if (mm_total) begin
                                state   <= S_ERROR;
                                red_led <= 1'b1;
                                blink   <= '0;
                                if (fail_cnt != 4'hF) fail_cnt <= fail_cnt + 4'd1;
                            end else begin
                                state     <= S_OPEN;
                                door_open <= 1'b1;
                                green_led <= 1'b1;
                                fail_cnt  <= '0;
                            end
                        end else begin
                            state     <= S_ENTRY;
                            digit_cnt <= digit_cnt + 4'd1;
                            mismatch  <= mm_total;
                        end
                    end else if (state == S_IDLE) begin
                        if (code_we) code_reg <= code_in;
                    end else if (timer == TO_LAST) begin
                        state     <= S_IDLE;
                        digit_cnt <= '0;
                        mismatch  <= 1'b0;
                        timer     <= '0;
                    end else begin
                        timer <= timer + 16'd1;
                    end
                end
                S_OPEN: begin
                    if (timer == OPEN_LAST) begin
                        state     <= S_IDLE;
                        door_open <= 1'b0;
                        green_led <= 1'b0;
                        timer     <= '0;
                    end else begin
                        timer <= timer + 16'd1;
                    end
                end
                S_ERROR: begin
                    if (timer == ERR_LAST) begin
                        red_led <= 1'b0;
                        timer   <= '0;
                        blink   <= '0;
                        state   <= S_IDLE;
`ifdef LOCKOUT_EN
                        if (fail_cnt >= FAIL_LIMIT) begin
                            state      <= S_LOCKOUT;
                            locked_out <= 1'b1;
                        end
`endif
                    end else begin
                        timer <= timer + 16'd1;
                        // Blink phase restarts each 2*BLINK_HALF cycles with the LED on.
                        if (blink == BLINK_LAST) begin
                            blink   <= '0;
                            red_led <= 1'b1;
                        end else begin
                            blink   <= blink + 16'd1;
                            red_led <= (blink + 16'd1) < BH;
                        end
                    end
                end
`ifdef LOCKOUT_EN
                S_LOCKOUT: begin
                    if (timer == LOCK_LAST) begin
                        state      <= S_IDLE;
                        locked_out <= 1'b0;
                        fail_cnt   <= '0;
                        timer      <= '0;
                    end else begin
                        timer <= timer + 16'd1;
                    end
                end
`endif
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_door_lock_ctrl.sv
// tb/tb_door_lock_ctrl.sv - randomized bench for door_lock_ctrl against a queue-based code model
module tb_door_lock_ctrl;

    localparam int NK = 4;
    localparam int CL = 4;
    localparam int KW = 2;
    localparam int TIMEOUT = 10;
    localparam int OPEN_TIME = 3;
    localparam int BLINK_HALF = 1;
    localparam int BLINKS = 3;
    localparam int MAX_FAIL = 3;
    localparam int LOCKOUT_TIME = 20;

    localparam int M_IDLE = 0, M_ENTRY = 1, M_OPEN = 2, M_ERROR = 3, M_LOCK = 4;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic [NK-1:0]  btn = '0;
    logic           code_we = 1'b0;
    logic [CL*KW-1:0] code_in = '0;
    logic           door_open, green_led, red_led, locked_out;
    logic [3:0]     fail_cnt;

    door_lock_ctrl dut (
        .clk(clk), .reset(reset), .btn(btn), .code_we(code_we), .code_in(code_in),
        .door_open(door_open), .green_led(green_led), .red_led(red_led),
        .locked_out(locked_out), .fail_cnt(fail_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    int m_mode, m_left, m_age, m_idle, m_fail;
    int m_code[CL];
    int m_keys[$];
    logic [NK-1:0] m_prev;

    int n_open, n_green, n_red, n_lock;
    logic [31:0] red_hist;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_mode = M_IDLE; m_left = 0; m_age = 0; m_idle = 0; m_fail = 0;
        m_code[0] = 0; m_code[1] = 2; m_code[2] = 1; m_code[3] = 3;
        m_keys.delete();
        m_prev = '0;
    endfunction

    function automatic void model_edge(input logic [NK-1:0] b, input logic we, input logic [CL*KW-1:0] ci);
        logic [NK-1:0] rise;
        int key;
        bit ok;
        rise = b & ~m_prev;
        m_prev = b;
        key = -1;
        if ($countones(rise) == 1)
            for (int i = 0; i < NK; i++) if (rise[i]) key = i;
        case (m_mode)
            M_IDLE, M_ENTRY: begin
                if (rise != '0) begin
                    m_keys.push_back(key);
                    m_idle = 0;
                    if (m_keys.size() == CL) begin
                        ok = 1'b1;
                        for (int i = 0; i < CL; i++) if (m_keys[i] != m_code[i]) ok = 1'b0;
                        m_keys.delete();
                        if (ok) begin
                            m_mode = M_OPEN; m_left = OPEN_TIME; m_fail = 0;
                        end else begin
                            m_mode = M_ERROR; m_left = 2 * BLINKS * BLINK_HALF; m_age = 0;
                            if (m_fail < 15) m_fail++;
                        end
                    end else begin
                        m_mode = M_ENTRY;
                    end
                end else if (m_mode == M_IDLE) begin
                    if (we) for (int i = 0; i < CL; i++) m_code[i] = int'(ci[i*KW +: KW]);
                end else begin
                    m_idle++;
                    if (m_idle == TIMEOUT) begin
                        m_mode = M_IDLE;
                        m_keys.delete();
                    end
                end
            end
            M_OPEN: begin
                m_left--;
                if (m_left == 0) m_mode = M_IDLE;
            end
            M_ERROR: begin
                m_age++;
                m_left--;
                if (m_left == 0) begin
                    m_mode = M_IDLE;
`ifdef LOCKOUT_EN
                    if (m_fail >= MAX_FAIL) begin
                        m_mode = M_LOCK; m_left = LOCKOUT_TIME;
                    end
`endif
                end
            end
            M_LOCK: begin
                m_left--;
                if (m_left == 0) begin
                    m_mode = M_IDLE; m_fail = 0;
                end
            end
            default: m_mode = M_IDLE;
        endcase
    endfunction

    task automatic check_outputs(input string tag);
        logic exp_red;
        exp_red = (m_mode == M_ERROR) && (((m_age / BLINK_HALF) % 2) == 0);
        check({tag, ":door_open"}, 32'(door_open), 32'(m_mode == M_OPEN));
        check({tag, ":green_led"}, 32'(green_led), 32'(m_mode == M_OPEN));
        check({tag, ":red_led"}, 32'(red_led), 32'(exp_red));
        check({tag, ":locked_out"}, 32'(locked_out), 32'(m_mode == M_LOCK));
        check({tag, ":fail_cnt"}, 32'(fail_cnt), 32'(m_fail));
    endtask

    task automatic clear_stats();
        n_open = 0; n_green = 0; n_red = 0; n_lock = 0; red_hist = '0;
    endtask

    task automatic step(input logic [NK-1:0] b, input logic we, input logic [CL*KW-1:0] ci, input string tag);
        btn = b; code_we = we; code_in = ci;
        @(posedge clk);
        model_edge(b, we, ci);
        #1;
        check_outputs(tag);
        n_open  += int'(door_open);
        n_green += int'(green_led);
        n_red   += int'(red_led);
        n_lock  += int'(locked_out);
        red_hist = {red_hist[30:0], red_led};
    endtask

    task automatic press(input int k, input string tag);
        step(NK'(1) << k, 1'b0, '0, tag);
        step('0, 1'b0, '0, tag);
    endtask

    task automatic idle_steps(input int n, input string tag);
        for (int i = 0; i < n; i++) step('0, 1'b0, '0, tag);
    endtask

    task automatic do_reset(input logic [NK-1:0] b);
        btn = b; code_we = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        check_outputs("reset");
        @(posedge clk);
        #1;
        check_outputs("reset_hold");
        reset = 1'b0;
    endtask

    initial begin
        logic [NK-1:0] b;
        logic we;
        int r;

        model_reset();
        do_reset('0);

        // correct code spaced two cycles apart
        clear_stats();
        press(0, "ok"); press(2, "ok"); press(1, "ok"); press(3, "ok");
        idle_steps(6, "ok_tail");
        check("ok_open_cycles", 32'(n_open), 32'(OPEN_TIME));
        check("ok_green_cycles", 32'(n_green), 32'(OPEN_TIME));
        check("ok_fail_cnt", 32'(fail_cnt), 32'd0);

        // wrong code: full code collected, then blink pattern 1,0,1,0,1,0
        clear_stats();
        press(0, "bad"); press(1, "bad"); press(1, "bad");
        check("bad_no_early_exit", 32'(n_red), 32'd0);
        step(NK'(1) << 3, 1'b0, '0, "bad");
        idle_steps(7, "bad_tail");
        check("bad_red_pattern", red_hist, 32'h0000_00A8);
        check("bad_fail_cnt", 32'(fail_cnt), 32'd1);

        // timeout discards a partial code
        clear_stats();
        press(0, "to");
        idle_steps(9, "to_wait");
        check("to_no_led", 32'(n_red + n_open), 32'd0);
        press(0, "to2"); press(2, "to2"); press(1, "to2"); press(3, "to2");
        idle_steps(4, "to2_tail");
        check("to_then_open", 32'(n_open), 32'(OPEN_TIME));

        // code write in IDLE, then ignored during ENTRY
        step('0, 1'b1, 8'h00, "we_idle");
        clear_stats();
        press(0, "c0"); press(0, "c0"); press(0, "c0"); press(0, "c0");
        idle_steps(4, "c0_tail");
        check("new_code_opens", 32'(n_open), 32'(OPEN_TIME));
        clear_stats();
        press(0, "old"); press(2, "old"); press(1, "old"); press(3, "old");
        idle_steps(6, "old_tail");
        check("old_code_fails", 32'(n_red), 32'd3);
        clear_stats();
        press(0, "we_entry");
        step('0, 1'b1, 8'hD8, "we_entry");
        press(0, "we_entry"); press(0, "we_entry"); press(0, "we_entry");
        idle_steps(4, "we_entry_tail");
        check("we_entry_ignored", 32'(n_open), 32'(OPEN_TIME));

        // button held through reset release counts as a press
        do_reset(NK'(1));
        clear_stats();
        step(NK'(1), 1'b0, '0, "held");
        step('0, 1'b0, '0, "held");
        press(2, "held"); press(1, "held"); press(3, "held");
        idle_steps(4, "held_tail");
        check("held_first_press", 32'(n_open), 32'(OPEN_TIME));

        // three failures, then correct code attempted
        do_reset('0);
        for (int t = 0; t < 3; t++) begin
            press(1, "lk"); press(1, "lk"); press(1, "lk");
            step(NK'(1) << 1, 1'b0, '0, "lk");
            if (t < 2) idle_steps(7, "lk_gap");
        end
        clear_stats();
        idle_steps(7, "lk_wait");
        press(0, "lk_ok"); press(2, "lk_ok"); press(1, "lk_ok"); press(3, "lk_ok");
        idle_steps(20, "lk_tail");
`ifdef LOCKOUT_EN
        check("lock_cycles", 32'(n_lock), 32'(LOCKOUT_TIME));
        check("lock_ignores_code", 32'(n_open), 32'd0);
`else
        check("no_lock", 32'(n_lock), 32'd0);
        check("no_lock_opens", 32'(n_open), 32'(OPEN_TIME));
`endif
        check("lock_fail_cleared", 32'(fail_cnt), 32'd0);

        // reset mid-OPEN clears everything immediately
        press(0, "ro"); press(2, "ro"); press(1, "ro");
        step(NK'(1) << 3, 1'b0, '0, "ro");
        check("ro_open_before", 32'(door_open), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check("ro_door", 32'(door_open), 32'd0);
        check("ro_green", 32'(green_led), 32'd0);
        check("ro_red", 32'(red_led), 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
        btn = '0;

        // randomized traffic biased towards the currently expected digit
        for (int c = 0; c < 3000; c++) begin
            r = $urandom_range(0, 19);
            if (r < 10) b = '0;
            else if (r < 16) b = NK'(1) << m_code[m_keys.size() % CL];
            else if (r < 18) b = NK'(1) << $urandom_range(0, NK - 1);
            else b = NK'($urandom);
            we = ($urandom_range(0, 29) == 0);
            step(b, we, (CL*KW)'($urandom), "rand");
            if ($urandom_range(0, 399) == 0) do_reset(NK'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/door_lock_ctrl.md
DOOR_LOCK_CTRL -- requirements
Module: door_lock_ctrl

Interface
REQ-001 Parameter NUM_KEYS, default 4, number of keypad buttons (2..16).
REQ-002 Parameter CODE_LEN, default 4, number of key presses per code (1..8).
REQ-003 Parameter KW, default $clog2(NUM_KEYS), width of one key index.
REQ-004 Parameter RESET_CODE, default {3,1,2,0} packed, power-on code; digit i at bits [i*KW +: KW], and digit 0 is entered first.
REQ-005 Parameter TIMEOUT, default 10, idle cycles allowed between presses during entry.
REQ-006 Parameter OPEN_TIME, default 3, open duration in cycles.
REQ-007 Parameter BLINK_HALF, default 1, and BLINKS, default 3, red blink half-period in cycles and blink count.
REQ-008 Parameter MAX_FAIL, default 3, and LOCKOUT_TIME, default 20, failure limit and lockout duration (used only under LOCKOUT_EN).
REQ-009 clk  input  1  single clock; all state changes on its rising edge.
REQ-010 reset  input  1  asynchronous, active-high reset.
REQ-011 btn  input  NUM_KEYS  keypad levels, synchronous to clk; bit k corresponds to key index k.
REQ-012 code_we  input  1  code write strobe.
REQ-013 code_in  input  CODE_LEN*KW  new code, packed as RESET_CODE.
REQ-014 door_open  output  1  door unlock.
REQ-015 green_led  output  1  success indicator.
REQ-016 red_led  output  1  error blink.
REQ-017 locked_out  output  1  lockout active.
REQ-018 fail_cnt  output  4  consecutive failed attempts, saturating at 15.

Function
REQ-019 Press detection: bit k is pressed when sampled high at an edge and low at the previous edge; a press with more than one bit rising in the same edge is a single invalid (mismatching) press.
REQ-020 States: IDLE, ENTRY, OPEN, ERROR, LOCKOUT; all outputs are Moore-decoded from registered state.
REQ-021 IDLE: a press stores the mismatch flag for digit 0, sets digit count to 1, and goes to ENTRY (or directly evaluates per REQ-023 when CODE_LEN=1).
REQ-022 ENTRY: each press compares the key with the current digit and ORs a mismatch into a sticky flag; the full code is always collected before evaluation (no early abort on a wrong digit).
REQ-023 At the edge of the CODE_LEN-th press: no mismatch -> OPEN and fail_cnt cleared; otherwise -> ERROR and fail_cnt incremented (saturating).
REQ-024 Timeout counter clears on every press; TIMEOUT consecutive press-free cycles in ENTRY -> IDLE, with digits discarded and fail_cnt unchanged.
REQ-025 OPEN: door_open=green_led=1 for exactly OPEN_TIME cycles, then IDLE; presses are ignored.
REQ-026 ERROR: lasts 2*BLINKS*BLINK_HALF cycles; red_led=1 during the first BLINK_HALF cycles of each 2*BLINK_HALF period, starting high on the first ERROR cycle; presses are ignored; then IDLE (or LOCKOUT per REQ-031).
REQ-027 code_we is accepted only in IDLE and with no press on that edge: code register <= code_in at that edge; code_we is ignored in all other states and cycles.
REQ-028 Latency: final correct press detected at edge N -> door_open high from edge N through edge N+OPEN_TIME.

Reset
REQ-029 Reset, asynchronous and immediate from any state (including mid-entry, OPEN, ERROR, LOCKOUT), forces: state=IDLE, code=RESET_CODE, all timers/counters/flags=0, btn history=0, door_open=green_led=red_led=locked_out=0, fail_cnt=0.
REQ-030 At the first edge after deassertion, a btn bit already high is treated as a rising edge (press).

Configuration
REQ-031 With LOCKOUT_EN defined: if fail_cnt reaches MAX_FAIL at an ERROR entry, ERROR exits to LOCKOUT; locked_out=1 for LOCKOUT_TIME cycles; presses and code_we are ignored; the block then returns to IDLE with fail_cnt=0.
REQ-032 Without LOCKOUT_EN: no LOCKOUT state, locked_out tied 0, fail_cnt counts and saturates only.

Verification
REQ-033 Default params; presses 0,2,1,3 spaced 2 cycles apart -> door_open=green_led=1 for exactly 3 cycles after the 4th press; fail_cnt=0.
REQ-034 Presses 0,1,1,3 -> no exit before the 4th press; then ERROR for 6 cycles with red_led pattern 1,0,1,0,1,0; fail_cnt=1.
REQ-035 Press 0, then 10 idle cycles -> IDLE with no LED activity; a following 0,2,1,3 opens the door.
REQ-036 In IDLE, code_we with code_in={0,0,0,0} -> presses 0,0,0,0 open the door and 0,2,1,3 fails; the same code_we during ENTRY leaves the code unchanged.
REQ-037 LOCKOUT_EN: 3 wrong codes -> locked_out=1 for 20 cycles after the third ERROR with the correct code ignored, then fail_cnt=0; reset asserted mid-OPEN -> all outputs 0 immediately.
